// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Turns a byte stream from a UART receiver into register writes. A frame is
//   sync_byte, addr, data, checksum. The checksum makes addr + data + sum == 0 (mod 256).
//   addr[7:4] must be zero. A good frame raises a one-cycle write strobe. A bad or
//   timed-out frame raises a one-cycle error pulse and bumps a saturating error count.
//
// Ports
//   clock        in   single clock, rising edge
//   reset        in   synchronous active-high reset
//   byte_data    in   [7:0] received byte
//   byte_ready   in   high (one or more cycles) while byte_data holds a new byte
//   reg_wr_en    out  one-cycle register write strobe
//   reg_addr     out  [3:0] register write address (holds last written value)
//   reg_wr_data  out  [7:0] register write data (holds last written value)
//   frame_ok     out  one-cycle pulse, frame committed
//   frame_err    out  one-cycle pulse, frame discarded
//   err_count    out  [7:0] saturating count of discarded frames
module uart_cmd_decoder #(
   parameter logic [7:0]  sync_byte      = 8'hA5,
   parameter int unsigned timeout_cycles = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] byte_data,
   input  logic       byte_ready,
   output logic       reg_wr_en,
   output logic [3:0] reg_addr,
   output logic [7:0] reg_wr_data,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [7:0] err_count
);

   typedef enum logic [2:0] {
      WAIT_SYNC,
      GET_ADDR,
      GET_DATA,
      GET_SUM,
      COMMIT
   } state_t;

   localparam logic [31:0] timeout_last = 32'(timeout_cycles - 1);

   state_t      state;
   logic        byte_ready_d;
   logic [7:0]  addr_byte;
   logic [7:0]  data_byte;
   logic [31:0] idle_cnt;

   logic        accept;
   logic [7:0]  sum;
   logic        frame_valid;
   logic        timed_out;
   logic [7:0]  err_count_inc;

   // A byte is taken only on the rising edge of byte_ready.
   // A long strobe therefore counts once.
   assign accept        = byte_ready & ~byte_ready_d;
   assign sum           = addr_byte + data_byte + byte_data;
   assign frame_valid   = (sum == 8'h00) && (addr_byte[7:4] == 4'h0);
   // An accepted byte in the same cycle takes priority over the timeout.
   assign timed_out     = !accept && (idle_cnt == timeout_last);
   assign err_count_inc = (err_count == 8'hFF) ? 8'hFF : err_count + 8'h01;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= WAIT_SYNC;
         byte_ready_d <= 1'b1;  // a strobe held high across reset release is not a new byte
         addr_byte    <= 8'h00;
         data_byte    <= 8'h00;
         idle_cnt     <= 32'd0;
         reg_wr_en    <= 1'b0;
         reg_addr     <= 4'h0;
         reg_wr_data  <= 8'h00;
         frame_ok     <= 1'b0;
         frame_err    <= 1'b0;
         err_count    <= 8'h00;
      end else begin
         byte_ready_d <= byte_ready;
         reg_wr_en    <= 1'b0;
         frame_ok     <= 1'b0;
         frame_err    <= 1'b0;

         unique case (state)
            WAIT_SYNC: begin
               // Non-sync bytes are dropped without raising an error.
               if (accept && (byte_data == sync_byte)) begin
                  state    <= GET_ADDR;
                  idle_cnt <= 32'd0;
               end
            end

            GET_ADDR, GET_DATA: begin
               if (accept) begin
                  // A sync byte here is ordinary payload.
                  if (state == GET_ADDR) begin
                     addr_byte <= byte_data;
                     state     <= GET_DATA;
                  end else begin
                     data_byte <= byte_data;
                     state     <= GET_SUM;
                  end
                  idle_cnt <= 32'd0;
               end else if (timed_out) begin
                  state     <= WAIT_SYNC;
                  idle_cnt  <= 32'd0;
                  frame_err <= 1'b1;
                  err_count <= err_count_inc;
               end else begin
                  idle_cnt <= idle_cnt + 32'd1;
               end
            end

            GET_SUM: begin
               if (accept) begin
                  idle_cnt <= 32'd0;
                  if (frame_valid) begin
                     // Outputs are registered.
                     // They are therefore visible for exactly the one cycle spent in COMMIT.
                     state       <= COMMIT;
                     reg_wr_en   <= 1'b1;
                     frame_ok    <= 1'b1;
                     reg_addr    <= addr_byte[3:0];
                     reg_wr_data <= data_byte;
                  end else begin
                     state     <= WAIT_SYNC;
                     frame_err <= 1'b1;
                     err_count <= err_count_inc;
                  end
               end else if (timed_out) begin
                  state     <= WAIT_SYNC;
                  idle_cnt  <= 32'd0;
                  frame_err <= 1'b1;
                  err_count <= err_count_inc;
               end else begin
                  idle_cnt <= idle_cnt + 32'd1;
               end
            end

            COMMIT: begin
               // A byte arriving here is dropped.
               // Its edge is still consumed through byte_ready_d.
               state <= WAIT_SYNC;
            end

            default: begin
               state    <= WAIT_SYNC;
               idle_cnt <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

   localparam int unsigned TimeoutCycles = 100;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic       reg_wr_en;
   logic [3:0] reg_addr;
   logic [7:0] reg_wr_data;
   logic       frame_ok;
   logic       frame_err;
   logic [7:0] err_count;

   uart_cmd_decoder #(
      .sync_byte     (8'hA5),
      .timeout_cycles(TimeoutCycles)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .reg_wr_en  (reg_wr_en),
      .reg_addr   (reg_addr),
      .reg_wr_data(reg_wr_data),
      .frame_ok   (frame_ok),
      .frame_err  (frame_err),
      .err_count  (err_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int wr_pulses = 0;
   int err_pulses = 0;
   logic [7:0] exp_err_count = 8'h00;

   // Count strobe cycles away from the active edge.
   always @(negedge clock) begin
      if (reg_wr_en) wr_pulses++;
      if (frame_err) err_pulses++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one byte for `hold` cycles, then one low cycle.
   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge clock);
      byte_data  = b;
      byte_ready = 1'b1;
      repeat (hold) @(negedge clock);
      byte_ready = 1'b0;
      @(negedge clock);
   endtask

   typedef struct {
      logic [7:0] b0, b1, b2, b3;
      logic       exp_wr;
      logic [3:0] exp_addr;
      logic [7:0] exp_data;
   } vec_t;

   // Send a four-byte frame; check outputs one cycle after the last byte edge.
   // Then check that the strobes last one cycle.
   task automatic apply_frame(input vec_t v, input int hold);
      send_byte(v.b0, hold);
      send_byte(v.b1, hold);
      send_byte(v.b2, hold);
      @(negedge clock);
      byte_data  = v.b3;
      byte_ready = 1'b1;
      @(negedge clock);
      if (!v.exp_wr && exp_err_count != 8'hFF) exp_err_count++;
      check("wr_en",     {31'd0, reg_wr_en},  {31'd0, v.exp_wr});
      check("frame_ok",  {31'd0, frame_ok},   {31'd0, v.exp_wr});
      check("frame_err", {31'd0, frame_err},  {31'd0, !v.exp_wr});
      check("reg_addr",  {28'd0, reg_addr},   {28'd0, v.exp_addr});
      check("reg_data",  {24'd0, reg_wr_data}, {24'd0, v.exp_data});
      check("err_count", {24'd0, err_count},  {24'd0, exp_err_count});
      @(negedge clock);
      check("pulse_end", {30'd0, reg_wr_en, frame_err}, 32'd0);
      repeat (hold) @(negedge clock);
      byte_ready = 1'b0;
      @(negedge clock);
   endtask

   vec_t vecs[7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
      $fatal(1);
   end

   initial begin
      int base_wr;
      int base_err;
      int cnt;
      vec_t v;

      // Sync-byte handling and checksum checks.
      // Addr/data hold through errors.
      vecs[0] = '{8'hA5, 8'h03, 8'h5A, 8'hA3, 1'b1, 4'h3, 8'h5A};
      vecs[1] = '{8'hA5, 8'h03, 8'h5A, 8'hA4, 1'b0, 4'h3, 8'h5A};
      vecs[2] = '{8'hA5, 8'h12, 8'h00, 8'hEE, 1'b0, 4'h3, 8'h5A};
      vecs[3] = '{8'hA5, 8'h0F, 8'hC3, 8'h2E, 1'b1, 4'hF, 8'hC3};
      vecs[4] = '{8'hA5, 8'h00, 8'h00, 8'h00, 1'b1, 4'h0, 8'h00};
      vecs[5] = '{8'hA5, 8'hA5, 8'hA5, 8'hB6, 1'b0, 4'h0, 8'h00};
      vecs[6] = '{8'hA5, 8'h05, 8'hA5, 8'h56, 1'b1, 4'h5, 8'hA5};

      reset      = 1'b1;
      byte_data  = 8'h00;
      byte_ready = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_outs", {18'd0, reg_wr_en, frame_ok, frame_err, reg_addr, reg_wr_data},
            32'd0);
      check("rst_errcnt", {24'd0, err_count}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      foreach (vecs[i]) apply_frame(vecs[i], 1);

      // Stray bytes before sync are dropped without an error pulse.
      base_err = err_pulses;
      send_byte(8'h00, 1);
      send_byte(8'h7F, 1);
      apply_frame('{8'hA5, 8'h01, 8'h01, 8'hFE, 1'b1, 4'h1, 8'h01}, 1);
      check("stray_no_err", err_pulses - base_err, 0);

      // Timeout: frame_err rises 100 clock edges after the edge that took 01.
      send_byte(8'hA5, 1);
      @(negedge clock);
      byte_data  = 8'h01;
      byte_ready = 1'b1;
      @(posedge clock);
      cnt = 0;
      while (cnt < 300) begin
         @(posedge clock);
         #1;
         byte_ready = 1'b0;
         cnt++;
         if (frame_err) break;
      end
      check("timeout_lat", cnt, TimeoutCycles);
      if (exp_err_count != 8'hFF) exp_err_count++;
      @(negedge clock);
      check("timeout_cnt", {24'd0, err_count}, {24'd0, exp_err_count});
      apply_frame('{8'hA5, 8'h03, 8'h5A, 8'hA3, 1'b1, 4'h3, 8'h5A}, 1);

      // A byte in the cycle the timeout would fire wins.
      base_err = err_pulses;
      @(negedge clock);
      byte_data  = 8'hA5;
      byte_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      byte_ready = 1'b0;
      repeat (TimeoutCycles - 1) @(posedge clock);
      @(negedge clock);
      byte_data  = 8'h02;
      byte_ready = 1'b1;
      @(negedge clock);
      byte_ready = 1'b0;
      send_byte(8'h10, 1);
      @(negedge clock);
      byte_data  = 8'hEE;
      byte_ready = 1'b1;
      @(negedge clock);
      check("tie_wr", {31'd0, reg_wr_en}, 32'd1);
      check("tie_addr_data", {20'd0, reg_addr, reg_wr_data}, {20'd0, 4'h2, 8'h10});
      byte_ready = 1'b0;
      repeat (2) @(negedge clock);
      check("tie_no_err", err_pulses - base_err, 0);

      // Long strobes and many bad frames: each byte counts once, err_count saturates.
      base_wr  = wr_pulses;
      base_err = err_pulses;
      v = '{8'hA5, 8'h03, 8'h5A, 8'hA4, 1'b0, 4'h2, 8'h10};
      for (int f = 0; f < 256; f++) apply_frame(v, 20);
      check("sat_err_pulses", err_pulses - base_err, 256);
      check("sat_no_wr", wr_pulses - base_wr, 0);
      check("sat_count", {24'd0, err_count}, 32'hFF);

      // Reset mid-frame, with byte_ready high across release.
      send_byte(8'hA5, 20);
      send_byte(8'h03, 20);
      base_wr  = wr_pulses;
      base_err = err_pulses;
      @(negedge clock);
      byte_data  = 8'hA5;
      byte_ready = 1'b1;
      reset      = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("mid_rst_outs", {18'd0, reg_wr_en, frame_ok, frame_err, reg_addr, reg_wr_data},
            32'd0);
      check("mid_rst_cnt", {24'd0, err_count}, 32'd0);
      repeat (5) @(negedge clock);
      byte_ready = 1'b0;
      @(negedge clock);
      // Had the held A5 been taken as sync, these would commit.
      send_byte(8'h03, 20);
      send_byte(8'h5A, 20);
      send_byte(8'hA3, 20);
      check("mid_rst_no_wr", wr_pulses - base_wr, 0);
      check("mid_rst_no_err", err_pulses - base_err, 0);
      exp_err_count = 8'h00;
      apply_frame('{8'hA5, 8'h01, 8'h01, 8'hFE, 1'b1, 4'h1, 8'h01}, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 The block SHALL have parameter sync_byte, default 8'hA5, the frame start marker.
REQ-002 The block SHALL have parameter timeout_cycles, default 50000, the maximum idle clocks allowed between bytes inside a frame.
REQ-003 The block SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port byte_data  input  8  received byte from the UART receiver.
REQ-006 The block SHALL have port byte_ready  input  1  high for one or more cycles when byte_data holds a new byte.
REQ-007 The block SHALL have port reg_wr_en  output  1  one-cycle register write strobe.
REQ-008 The block SHALL have port reg_addr  output  4  register write address.
REQ-009 The block SHALL have port reg_wr_data  output  8  register write data.
REQ-010 The block SHALL have port frame_ok  output  1  one-cycle pulse, frame committed.
REQ-011 The block SHALL have port frame_err  output  1  one-cycle pulse, frame discarded.
REQ-012 The block SHALL have port err_count  output  8  saturating count of discarded frames.

Function
REQ-013 Byte acceptance SHALL occur only on a byte_ready rising edge (byte_ready=1 now, registered byte_ready_d=0), sampling byte_data in that cycle; a multi-cycle-high byte_ready SHALL count as one byte.
REQ-014 The FSM states SHALL be WAIT_SYNC, GET_ADDR, GET_DATA, GET_SUM, COMMIT.
REQ-015 In WAIT_SYNC: accepted byte == sync_byte -> GET_ADDR; any other byte SHALL be ignored silently, with no frame_err.
REQ-016 In GET_ADDR: accepted byte -> latch as addr_byte, go to GET_DATA.
REQ-017 In GET_DATA: accepted byte -> latch as data_byte, go to GET_SUM.
REQ-018 In GET_SUM, on an accepted byte: the frame SHALL be valid iff (addr_byte + data_byte + byte) mod 256 == 0 and addr_byte[7:4] == 0.
REQ-019 Valid frame: go to COMMIT. In COMMIT, for exactly one cycle, assert reg_wr_en=1 and frame_ok=1, with reg_addr=addr_byte[3:0] and reg_wr_data=data_byte; then go to WAIT_SYNC.
REQ-020 Invalid frame: pulse frame_err in the next cycle, go to WAIT_SYNC, assert no reg_wr_en.
REQ-021 Latency SHALL be: checksum byte accepted in cycle N -> reg_wr_en/frame_ok (or frame_err) high in cycle N+1.
REQ-022 reg_addr and reg_wr_data SHALL hold their last written values when reg_wr_en=0.
REQ-023 An idle counter SHALL clear on every accepted byte and on entry to GET_ADDR, and SHALL increment every cycle in GET_ADDR, GET_DATA and GET_SUM.
REQ-024 When the idle counter reaches timeout_cycles-1 with no byte accepted that cycle, the FSM SHALL go to WAIT_SYNC and pulse frame_err in the next cycle.
REQ-025 A byte accepted in the same cycle the timeout would fire SHALL win, and no timeout SHALL occur.
REQ-026 The idle counter SHALL be at least 32 bits wide and SHALL NOT count in WAIT_SYNC or COMMIT.
REQ-027 A byte accepted while in COMMIT SHALL be dropped; the sender is required to space bytes by more than 1 cycle.
REQ-028 err_count SHALL increment by 1 on each frame_err pulse and saturate at 8'hFF.
REQ-029 sync_byte received in GET_ADDR or GET_DATA SHALL be treated as ordinary payload, with no resynchronisation.

Reset
REQ-030 While reset=1, the block SHALL force state=WAIT_SYNC, idle counter=0, reg_wr_en=0, frame_ok=0, frame_err=0, err_count=0, reg_addr=0, reg_wr_data=0, latched bytes=0, and byte_ready_d=1.
REQ-031 byte_ready_d=1 at reset SHALL ensure that a byte_ready held high across reset release is not accepted.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no reg_wr_en and no frame_err, and SHALL NOT increment err_count.

Verification
REQ-033 Bytes A5,03,5A,A3 -> one cycle after A3 edge: reg_wr_en=1, reg_addr=3, reg_wr_data=5A, frame_ok=1; err_count=0.
REQ-034 Bytes A5,03,5A,A4 -> frame_err one cycle after A4 edge, no reg_wr_en, err_count=1.
REQ-035 Bytes A5,12,00,EE (addr high nibble set) -> frame_err, no write.
REQ-036 Bytes 00,7F then A5,01,01,FE -> stray bytes ignored silently; write addr 1 data 01; frame_err never asserted.
REQ-037 Bytes A5,01 then silence with timeout_cycles=100 -> frame_err exactly 100 cycles after the 01 edge; a subsequent valid frame commits normally.
REQ-038 byte_ready held high 20 cycles per byte, 256 bad frames, reset pulsed mid-frame -> each byte counted once; err_count saturates at FF; after reset err_count=0 and the FSM is in WAIT_SYNC with no strobe.
